timer_sequencer: RTL and testbench
==================================

TIMER_SEQUENCER -- requirements
Module: timer_sequencer

Interface
REQ-001 Parameter LENGTH, default 4, sets the width of the counter datapath.
REQ-002 Parameter EndCount, default 9, is the counter's upper limit and the up-run terminal value.
REQ-003 Parameter BeginCount, default 0, is the counter's lower limit and the down-run terminal value.
REQ-004 Parameter RUNS_WIDTH, default 8, sets the width of Runs.
REQ-005 Port CLOCK, input, 1 bit: system clock; all state updates on its rising edge.
REQ-006 Port Reset, input, 1 bit: reset, asynchronous, active-high.
REQ-007 Port Start, input, 1 bit: request to begin a timed run.
REQ-008 Port Stop, input, 1 bit: abort the current run.
REQ-009 Port Pause, input, 1 bit: single-cycle pulse that toggles between RUN and PAUSE.
REQ-010 Port Dir, input, 1 bit: run direction, 1 = up, 0 = down; sampled with Start.
REQ-011 Port Preset, input, LENGTH bits: start value; sampled with Start.
REQ-012 Port Tick, input, 1 bit: single-cycle count-enable pulse.
REQ-013 Port Q, input, LENGTH bits: current value of the controlled counter.
REQ-014 Port S1, output, 1 bit: counter mode select, high bit.
REQ-015 Port S0, output, 1 bit: counter mode select, low bit.
REQ-016 Port P, output, LENGTH bits: counter parallel-load value (registered).
REQ-017 Port Busy, output, 1 bit: high in LOAD, RUN and PAUSE.
REQ-018 Port Done, output, 1 bit: high for the single cycle the controller spends in DONE.
REQ-019 Port Runs, output, RUNS_WIDTH bits: count of completed runs.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, RUN, PAUSE and DONE.
REQ-021 Counter mode codes {S1,S0} SHALL be 00 = hold, 01 = up, 10 = down, 11 = load; S1 and S0 are a combinational decode of state, Dir_r, Tick and Q.
REQ-022 In IDLE, Start=1 SHALL latch Preset into P and Dir into Dir_r, and the next state SHALL be LOAD.
REQ-023 Start SHALL be ignored while Busy=1.
REQ-024 In LOAD, {S1,S0} SHALL be 11, and the next state SHALL be RUN; the counter therefore holds Preset one edge after LOAD.
REQ-025 Terminal value T SHALL equal EndCount when Dir_r=1 and BeginCount when Dir_r=0.
REQ-026 In RUN with Tick=1 and Q!=T, {S1,S0} SHALL be 01 (Dir_r=1) or 10 (Dir_r=0); otherwise {S1,S0} SHALL be 00.
REQ-027 In RUN with Q==T, the next state SHALL be DONE, regardless of Tick; the counter is never commanded past T, so no wrap occurs.
REQ-028 If Preset==T, the run SHALL complete with no counting.
REQ-029 In DONE, Done SHALL be 1, Runs SHALL increment by 1 (mod 2^RUNS_WIDTH), {S1,S0} SHALL be 00, and the next state SHALL be IDLE.
REQ-030 A Pause pulse in RUN SHALL move the FSM to PAUSE, and a Pause pulse in PAUSE SHALL return it to RUN.
REQ-031 In PAUSE, {S1,S0} SHALL be 00, and Tick SHALL be ignored.
REQ-032 In IDLE, LOAD and DONE, Pause SHALL be ignored.
REQ-033 Stop=1 in LOAD, RUN or PAUSE SHALL force the next state to IDLE without incrementing Runs.
REQ-034 Stop SHALL take priority over Pause, Tick and the terminal condition.
REQ-035 In IDLE, {S1,S0} SHALL be 00.

Reset
REQ-036 Reset=1 SHALL immediately force state IDLE, P=0, Dir_r=0, Runs=0, Done=0 and Busy=0, including mid-run.
REQ-037 After Reset deasserts, the first Start SHALL be accepted on the next rising CLOCK edge.

Configuration
REQ-038 With AUTO_RELOAD_EN defined, a RUN reaching Q==T SHALL pass through DONE (Done pulse, Runs+1) and then enter LOAD again with the same P and Dir_r; Busy SHALL stay 1 and only Stop ends the sequence.
REQ-039 With AUTO_RELOAD_EN undefined, DONE SHALL always return to IDLE as stated in REQ-029.

Verification
REQ-040 Preset=3, Dir=1, Start, then 6 Ticks -> load (11) seen once; 01 asserted 6 times; Q reaches 9; one Done pulse; Runs=1; Busy low afterwards.
REQ-041 Preset=2, Dir=0, Start, Tick every cycle -> 10 asserted twice; Q reaches 0; Done; Q stays 0 with further Ticks (no wrap to 9).
REQ-042 Up run with Pause pulsed at Q=5, 4 Ticks, then Pause again -> Q held at 5 during PAUSE; counting resumes; Done at Q=9.
REQ-043 Stop and Pause asserted together in RUN at Q=4 -> IDLE next cycle; Runs unchanged; no Done.
REQ-044 Reset asserted mid-RUN -> Busy=0, P=0 and Runs=0 without waiting for a clock edge; Start while Busy was ignored earlier.
REQ-045 AUTO_RELOAD_EN defined, Preset=7, Dir=1, 10 Ticks -> Done pulses at each Q=9; reload to 7 after each; Runs=2; Busy stays 1 until Stop.

Source files
------------

// File: rtl/timer_sequencer.sv
// timer_sequencer -- run controller for an external loadable up/down counter.
// The controller loads a start value into the counter and then steps it with
// the Tick pulse until the terminal value for the chosen direction is reached.
// Pause freezes a run and Stop aborts it. Runs counts how many runs completed.
//
// Optional feature macro: AUTO_RELOAD_EN
//   When defined, a completed run reloads the same start value and direction
//   and runs again. The controller stays busy until Stop ends the sequence.
//   When undefined (default), every completed run returns to IDLE.

module timer_sequencer #(
   parameter int LENGTH     = 4,
   parameter int EndCount   = 9,
   parameter int BeginCount = 0,
   parameter int RUNS_WIDTH = 8
) (
   input  logic                  CLOCK,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic                  Stop,
   input  logic                  Pause,
   input  logic                  Dir,
   input  logic [LENGTH-1:0]     Preset,
   input  logic                  Tick,
   input  logic [LENGTH-1:0]     Q,
   output logic                  S1,
   output logic                  S0,
   output logic [LENGTH-1:0]     P,
   output logic                  Busy,
   output logic                  Done,
   output logic [RUNS_WIDTH-1:0] Runs
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // Mode codes understood by the external counter.
   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_UP   = 2'b01,
      MODE_DOWN = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

   localparam logic [LENGTH-1:0] END_VAL   = LENGTH'(EndCount);
   localparam logic [LENGTH-1:0] BEGIN_VAL = LENGTH'(BeginCount);

   state_e                state_q, state_d;
   logic [LENGTH-1:0]     preset_q, preset_d;
   logic                  dir_q, dir_d;
   logic [RUNS_WIDTH-1:0] runs_q, runs_d;
   mode_e                 mode;
   logic [LENGTH-1:0]     term_val;
   logic                  at_term;
   logic                  accept_start;

   // The terminal value depends only on the latched direction, so a run
   // never has its end point changed by Dir toggling mid-run.
   assign term_val = dir_q ? END_VAL : BEGIN_VAL;
   assign at_term  = (Q == term_val);

   // Start is only meaningful in IDLE; Busy covers every other live state.
   assign accept_start = (state_q == ST_IDLE) && Start;

   // State register; Reset drops the controller to IDLE at once, mid-run too.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge CLOCK or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Run parameters and completed-run counter.
   always_ff @(posedge CLOCK or posedge Reset) begin
      if (Reset) begin
         preset_q <= '0;
         dir_q    <= 1'b0;
         runs_q   <= '0;
      end else begin
         preset_q <= preset_d;
         dir_q    <= dir_d;
         runs_q   <= runs_d;
      end
   end

   // Next values of the run parameters and of the run counter.
   always_comb begin
      // NOTE: every signal assigned in always_comb gets a default first, so
      // no path leaves it unassigned and no latch is inferred.
      preset_d = preset_q;
      dir_d    = dir_q;
      runs_d   = runs_q;
      if (accept_start) begin
         preset_d = Preset;
         dir_d    = Dir;
      end
      // The counter wraps naturally at 2^RUNS_WIDTH.
      if (state_q == ST_DONE) begin
         runs_d = runs_q + 1'b1;
      end
   end

   // Next-state logic. Stop outranks Pause, Tick and the terminal test.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (Start) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (Stop) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (Stop) begin
               state_d = ST_IDLE;
            end else if (at_term) begin
               // Covers Preset equal to the terminal value: no counting at all.
               state_d = ST_DONE;
            end else if (Pause) begin
               state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (Stop) begin
               state_d = ST_IDLE;
            end else if (Pause) begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
`ifdef AUTO_RELOAD_EN
            // Reload with the latched start value; only Stop breaks the loop.
            if (Stop) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_LOAD;
            end
`else
            state_d = ST_IDLE;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Counter mode decode. The counter is only stepped while Q is short of the
   // terminal value, so it can never be driven past it and never wraps.
   always_comb begin
      mode = MODE_HOLD;
      unique case (state_q)
         ST_LOAD: mode = MODE_LOAD;
         ST_RUN: begin
            if (!Stop && Tick && !at_term) begin
               mode = dir_q ? MODE_UP : MODE_DOWN;
            end
         end
         default: mode = MODE_HOLD;
      endcase
   end

   assign S1 = mode[1];
   assign S0 = mode[0];
   assign P  = preset_q;
   assign Runs = runs_q;
   assign Done = (state_q == ST_DONE);

`ifdef AUTO_RELOAD_EN
   // DONE is only a pass-through step of an ongoing sequence.
   assign Busy = (state_q != ST_IDLE);
`else
   assign Busy = (state_q == ST_LOAD) || (state_q == ST_RUN) ||
                 (state_q == ST_PAUSE);
`endif

endmodule

// File: tb/tb_timer_sequencer.sv
// tb_timer_sequencer -- directed bench for timer_sequencer with a model of
// the external counter and a Done scoreboard checked by a separate monitor.
module tb_timer_sequencer;

   localparam int LENGTH     = 4;
   localparam int RUNS_WIDTH = 8;

   logic                  CLOCK = 1'b0;
   logic                  Reset;
   logic                  Start, Stop, Pause, Dir, Tick;
   logic [LENGTH-1:0]     Preset;
   logic [LENGTH-1:0]     Q;
   logic                  S1, S0;
   logic [LENGTH-1:0]     P;
   logic                  Busy, Done;
   logic [RUNS_WIDTH-1:0] Runs;

   int checks   = 0;
   int failures = 0;

   // Mode occurrence counters, sampled by the monitor each cycle.
   int n_load = 0;
   int n_up   = 0;
   int n_down = 0;

   // Expected {Q, Runs} seen during each Done pulse.
   typedef struct {
      logic [LENGTH-1:0]     q;
      logic [RUNS_WIDTH-1:0] runs;
   } done_t;
   done_t sb_q[$];

   timer_sequencer #(
      .LENGTH(LENGTH), .EndCount(9), .BeginCount(0), .RUNS_WIDTH(RUNS_WIDTH)
   ) dut (
      .CLOCK(CLOCK), .Reset(Reset), .Start(Start), .Stop(Stop), .Pause(Pause),
      .Dir(Dir), .Preset(Preset), .Tick(Tick), .Q(Q), .S1(S1), .S0(S0),
      .P(P), .Busy(Busy), .Done(Done), .Runs(Runs)
   );

   always #5 CLOCK = ~CLOCK;

   // External counter model: hold / up / down / load.
   logic [LENGTH-1:0] q_model = '0;
   assign Q = q_model;
   always @(posedge CLOCK) begin
      case ({S1, S0})
         2'b01:   q_model <= q_model + 1'b1;
         2'b10:   q_model <= q_model - 1'b1;
         2'b11:   q_model <= P;
         default: q_model <= q_model;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: counts counter commands and scores each Done pulse.
   always @(negedge CLOCK) begin
      if (!Reset) begin
         case ({S1, S0})
            2'b11:   n_load++;
            2'b01:   n_up++;
            2'b10:   n_down++;
            default: ;
         endcase
         if (Done) begin
            done_t e;
            check("done_pending", 32'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               check("done_q", 32'(Q), 32'(e.q));
               check("done_runs", 32'(Runs), 32'(e.runs));
            end
         end
      end
   end

   task automatic step();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic expect_done(input logic [LENGTH-1:0] q,
                              input logic [RUNS_WIDTH-1:0] runs);
      done_t e;
      e.q    = q;
      e.runs = runs;
      sb_q.push_back(e);
   endtask

   // Wait until the controller is back in IDLE, with a cycle budget.
   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge CLOCK);
      while ((Busy || Done) && n < 60) begin
         @(negedge CLOCK);
         n++;
      end
      check({name, "_idle_timeout"}, 32'(n < 60), 1);
      step();
   endtask

   task automatic start_run(input logic [LENGTH-1:0] pre, input logic dir);
      Preset = pre;
      Dir    = dir;
      Start  = 1'b1;
      step();
      Start  = 1'b0;
   endtask

   initial begin
      int up0, down0, load0;
      Reset = 1'b1; Start = 1'b0; Stop = 1'b0; Pause = 1'b0;
      Dir = 1'b0; Tick = 1'b0; Preset = '0;
      repeat (2) step();
      check("rst_busy", 32'(Busy), 0);
      check("rst_done", 32'(Done), 0);
      check("rst_p", 32'(P), 0);
      check("rst_runs", 32'(Runs), 0);
      check("rst_mode", 32'({S1, S0}), 0);
      Reset = 1'b0;

`ifdef AUTO_RELOAD_EN
      // Auto reload: Preset 7 up; two completed runs, busy throughout.
      load0 = n_load;
      start_run(4'd7, 1'b1);
      step();
      expect_done(4'd9, 8'd0);
      expect_done(4'd9, 8'd1);
      Tick = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLOCK);
         check("ar_busy", 32'(Busy), 1);
         step();
      end
      Tick = 1'b0;
      check("ar_q_reloaded", 32'(Q), 7);
      check("ar_runs", 32'(Runs), 2);
      check("ar_loads", 32'(n_load - load0), 3);
      check("ar_p", 32'(P), 7);
      Stop = 1'b1;
      step();
      Stop = 1'b0;
      check("ar_stop_busy", 32'(Busy), 0);
      check("ar_stop_runs", 32'(Runs), 2);
`else
      // Up run from 3: one load, six up commands, Q=9, Runs=1.
      load0 = n_load; up0 = n_up;
      expect_done(4'd9, 8'd0);
      start_run(4'd3, 1'b1);
      check("up_busy", 32'(Busy), 1);
      step();
      Tick = 1'b1;
      repeat (6) step();
      Tick = 1'b0;
      wait_idle("up");
      check("up_loads", 32'(n_load - load0), 1);
      check("up_ups", 32'(n_up - up0), 6);
      check("up_q", 32'(Q), 9);
      check("up_runs", 32'(Runs), 1);
      check("up_busy_after", 32'(Busy), 0);

      // Down run from 2 with Tick every cycle: no wrap past 0.
      down0 = n_down; up0 = n_up;
      expect_done(4'd0, 8'd1);
      Tick = 1'b1;
      start_run(4'd2, 1'b0);
      wait_idle("down");
      repeat (3) step();
      Tick = 1'b0;
      check("down_downs", 32'(n_down - down0), 2);
      check("down_ups", 32'(n_up - up0), 0);
      check("down_q_nowrap", 32'(Q), 0);
      check("down_runs", 32'(Runs), 2);

      // Pause at Q=5, four ignored Ticks, resume to 9; Start while busy.
      expect_done(4'd9, 8'd2);
      start_run(4'd3, 1'b1);
      step();
      Tick = 1'b1;
      repeat (2) step();
      Tick = 1'b0; Pause = 1'b1;
      step();
      Pause = 1'b0; Tick = 1'b1; Start = 1'b1; Preset = 4'd0;
      up0 = n_up;
      for (int k = 0; k < 4; k++) begin
         step();
         @(negedge CLOCK);
         check("pause_q", 32'(Q), 5);
         check("pause_mode", 32'({S1, S0}), 0);
      end
      Start = 1'b0;
      check("pause_ups", 32'(n_up - up0), 0);
      check("pause_p_kept", 32'(P), 3);
      check("pause_busy", 32'(Busy), 1);
      step();
      Tick = 1'b0; Pause = 1'b1;
      step();
      Pause = 1'b0; Tick = 1'b1;
      wait_idle("pause");
      Tick = 1'b0;
      check("pause_q_end", 32'(Q), 9);
      check("pause_runs", 32'(Runs), 3);

      // Stop together with Pause at Q=4: straight to IDLE, no Done.
      start_run(4'd2, 1'b1);
      step();
      Tick = 1'b1;
      repeat (2) step();
      Tick = 1'b0; Stop = 1'b1; Pause = 1'b1;
      step();
      Stop = 1'b0; Pause = 1'b0;
      @(negedge CLOCK);
      check("stop_busy", 32'(Busy), 0);
      check("stop_done", 32'(Done), 0);
      repeat (3) step();
      check("stop_runs", 32'(Runs), 3);
      check("stop_q", 32'(Q), 4);

      // Reset mid-run clears outputs without a clock edge.
      start_run(4'd1, 1'b1);
      step();
      Tick = 1'b1;
      step();
      Tick = 1'b0;
      #2;
      Reset = 1'b1;
      #1;
      check("mrst_busy", 32'(Busy), 0);
      check("mrst_p", 32'(P), 0);
      check("mrst_runs", 32'(Runs), 0);
      check("mrst_done", 32'(Done), 0);
      step();
      Reset = 1'b0;

      // First Start after reset is taken on the next edge; Preset==T
      // completes with no counting.
      up0 = n_up;
      expect_done(4'd9, 8'd0);
      start_run(4'd9, 1'b1);
      check("post_rst_busy", 32'(Busy), 1);
      check("post_rst_p", 32'(P), 9);
      wait_idle("preset_eq_t");
      check("eq_t_ups", 32'(n_up - up0), 0);
      check("eq_t_runs", 32'(Runs), 1);
      check("eq_t_q", 32'(Q), 9);
`endif

      repeat (2) step();
      check("sb_empty", 32'(sb_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
